averager_sequencer: RTL and testbench
=====================================

Name: averager_sequencer

Overview:
- Timing and address sequencer for the BRAM averaging datapath.
- Generalises the single-channel averager counter with:
  - 2^CH_LOG2 time-interleaved channels.
  - Single-shot mode that stops after a programmed number of averages.
  - Configurable output pipeline delay to match the accumulator latency.
  - Asynchronous active-low reset.
- Drives accumulator init/wen/address; reports the completed average count to the AXI-facing status registers.

Parameters:
FAST_COUNT_WIDTH, 5, width of the sample-within-period counter
SLOW_COUNT_WIDTH, 10, width of the averaging (frame) counter and n_avg
CH_LOG2, 1, log2 of channel count; channels are visited one period each
OUT_LATENCY, 2, clock cycles of delay applied to init/wen/address (must be >= 1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
clken  in  1  sample enable; all counters hold when low
restart  in  1  pulse; start or re-align averaging
count_max  in  FAST_COUNT_WIDTH  last fast-count index (period = count_max+1 samples)
avg_target  in  SLOW_COUNT_WIDTH  frames per average; 0 = continuous
init  out  1  accumulator overwrite (first frame), delayed OUT_LATENCY
wen  out  1  accumulator write enable, delayed OUT_LATENCY
address  out  CH_LOG2+FAST_COUNT_WIDTH  {channel, fast count}, delayed OUT_LATENCY
ready  out  1  one-cycle pulse: average complete, n_avg valid
busy  out  1  state is RUN
n_avg  out  SLOW_COUNT_WIDTH  frames in last completed average

Behaviour:
- Reset (resetn low, async):
  - State IDLE; fc, ch, sc, restart latch and pipeline cleared.
  - All outputs 0.
  - Holds until resetn is sampled high.
- Counters (advance only when clken=1 and state=RUN):
  - fc counts 0..cm, where cm is count_max captured at frame start.
  - At fc==cm: fc->0 and ch increments.
  - At fc==cm and ch==2^CH_LOG2-1 (frame end): ch->0 and sc increments.
  - sc saturates at 2^SLOW_COUNT_WIDTH-1.
- States: IDLE, RUN, DONE.
  - IDLE: fc=ch=sc=0.
    - restart=1 -> RUN next cycle, first-frame flag set, cm <= count_max.
  - RUN: issues one wen per clken cycle.
    - restart while RUN sets a pending latch.
    - At frame end: if pending, or (avg_target!=0 and sc+1==avg_target):
      - ready=1 for one cycle; n_avg <= sc+1.
      - If pending: stay RUN, clear sc and latch, set first-frame flag, recapture cm.
      - Else: go to DONE.
    - Otherwise at frame end: first-frame flag cleared, cm recaptured.
  - DONE: no wen.
    - restart -> RUN exactly as from IDLE; n_avg holds.
- restart coincident with frame end in RUN: treated as pending for that boundary.
  - Completes with n_avg=sc+1, then a new average starts the next cycle.
- init=1 for every wen of the first frame of an average, else 0.
- Output pipeline: {init, wen, address} pass through OUT_LATENCY registers.
  - ready/n_avg are timed to assert OUT_LATENCY cycles after the final wen was issued (pipeline drained).
- clken=0: fc/ch/sc frozen; pipeline still shifts with wen=0; restart still latched.
- count_max changes mid-frame: ignored until next frame start.
- count_max=0: one-sample periods; legal.
- avg_target change: takes effect at the next frame-end comparison.
- busy=1 iff state RUN.

Test Plan:
- Reset then idle: resetn low 3 cycles, release, clken=1 with no restart, 20 cycles -> wen=0, init=0, ready=0, busy=0, address=0.
- Single-shot sequencing: CH_LOG2=1, count_max=3, avg_target=2, restart pulse.
  - wen asserted for 16 consecutive cycles, starting OUT_LATENCY+1 cycles after restart.
  - Address sequence 0,1,2,3,32,33,34,35 (ch bit at bit 5, FAST_COUNT_WIDTH=5), repeated twice.
  - init=1 for first 8 wen only.
  - ready pulses once, n_avg=2, then DONE with busy=0.
- Continuous with restart: avg_target=0, count_max=15, restart, then second restart mid-frame 3.
  - ready at end of frame 3 with n_avg=3.
  - Next frame init=1.
  - No gap in wen.
- clken gating: toggle clken 1/0 each cycle during RUN -> address advances only on clken=1, wen mirrors delayed clken, sequence unchanged.
- Async reset mid-RUN: assert resetn low between clock edges -> all outputs 0 immediately; restart after release -> fresh average with init=1 and address 0.
- Saturation and boundaries:
  - SLOW_COUNT_WIDTH=3, continuous, restart after 10 frames -> n_avg=7.
  - count_max=0 -> address alternates 0,32.
  - count_max changed mid-frame -> applies at next frame.

Source files
------------

// File: rtl/averager_sequencer.sv
// averager_sequencer: timing and address sequencer for the BRAM averaging datapath
// Ports: clk, resetn (async active-low); clken sample enable; restart start/re-align pulse;
//   count_max last fast index; avg_target frames per average (0 = continuous);
//   init/wen/address accumulator controls delayed OUT_LATENCY; ready completion pulse
//   aligned with the final delayed wen; busy while running; n_avg frames in last average.
module averager_sequencer #(
    parameter int FAST_COUNT_WIDTH = 5,
    parameter int SLOW_COUNT_WIDTH = 10,
    parameter int CH_LOG2 = 1,
    parameter int OUT_LATENCY = 2
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                clken,
    input  logic                                restart,
    input  logic [FAST_COUNT_WIDTH-1:0]         count_max,
    input  logic [SLOW_COUNT_WIDTH-1:0]         avg_target,
    output logic                                init,
    output logic                                wen,
    output logic [CH_LOG2+FAST_COUNT_WIDTH-1:0] address,
    output logic                                ready,
    output logic                                busy,
    output logic [SLOW_COUNT_WIDTH-1:0]         n_avg
);
    localparam int FW = FAST_COUNT_WIDTH;
    localparam int SW = SLOW_COUNT_WIDTH;
    localparam int AW = CH_LOG2 + FW;
    localparam int PW = 3 + AW + SW;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state_q, state_d;
    logic [FW-1:0]     fc_q, fc_d, cm_q, cm_d;
    logic [CH_LOG2-1:0] ch_q, ch_d;
    logic [SW-1:0]     sc_q, sc_d, sc1, n_avg_q, n_avg_d;
    logic              first_q, first_d, pend_q, pend_d;
    logic              issue, frame_end, finish;
    // each stage carries {ready, init, wen, address, completed count}
    logic [PW-1:0]     pipe_q [OUT_LATENCY];
    logic [PW-1:0]     pipe_in [OUT_LATENCY];
    always_comb begin
        state_d = state_q;
        fc_d = fc_q;
        ch_d = ch_q;
        sc_d = sc_q;
        cm_d = cm_q;
        first_d = first_q;
        pend_d = pend_q;
        issue = (state_q == RUN) && clken;
        frame_end = issue && (fc_q == cm_q) && (&ch_q);
        sc1 = (&sc_q) ? sc_q : sc_q + 1'b1;
        // a restart arriving on the frame-end cycle counts as already pending
        finish = frame_end && (pend_q || restart || (avg_target != '0 && sc1 == avg_target));
        if (state_q != RUN) begin
            if (restart) begin
                state_d = RUN;
                first_d = 1'b1;
                cm_d = count_max;
                fc_d = '0;
                ch_d = '0;
                sc_d = '0;
                pend_d = 1'b0;
            end
        end else begin
            pend_d = pend_q || restart;
            if (issue) begin
                fc_d = (fc_q == cm_q) ? '0 : fc_q + 1'b1;
                ch_d = (fc_q == cm_q) ? ch_q + 1'b1 : ch_q;
                if (frame_end) begin
                    cm_d = count_max;
                    first_d = finish;
                    sc_d = finish ? '0 : sc1;
                    pend_d = 1'b0;
                    state_d = (finish && !(pend_q || restart)) ? DONE : RUN;
                end
            end
        end
        pipe_in[0] = {finish, issue && first_q, issue, ch_q, fc_q, sc1};
        for (int i = 1; i < OUT_LATENCY; i++) pipe_in[i] = pipe_q[i-1];
        // n_avg is loaded on the same edge that presents ready
        n_avg_d = pipe_in[OUT_LATENCY-1][PW-1] ? pipe_in[OUT_LATENCY-1][SW-1:0] : n_avg_q;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            fc_q <= '0;
            ch_q <= '0;
            sc_q <= '0;
            cm_q <= '0;
            first_q <= 1'b0;
            pend_q <= 1'b0;
            n_avg_q <= '0;
            for (int i = 0; i < OUT_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            fc_q <= fc_d;
            ch_q <= ch_d;
            sc_q <= sc_d;
            cm_q <= cm_d;
            first_q <= first_d;
            pend_q <= pend_d;
            n_avg_q <= n_avg_d;
            for (int i = 0; i < OUT_LATENCY; i++) pipe_q[i] <= pipe_in[i];
        end
    end
    assign {ready, init, wen, address} = pipe_q[OUT_LATENCY-1][PW-1:SW];
    assign busy = (state_q == RUN);
    assign n_avg = n_avg_q;
endmodule

// File: tb/tb_averager_sequencer.sv
// tb_averager_sequencer: self-checking bench for averager_sequencer
`timescale 1ns/1ps
module tb_averager_sequencer;
    localparam int FW = 5;
    localparam int SW = 10;
    localparam int CL = 1;
    localparam int L = 2;
    localparam int NCH = 2;
    localparam int AW = CL + FW;
    localparam int SMAX = 1023;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic clken = 1'b0;
    logic restart = 1'b0;
    logic [FW-1:0] count_max = '0;
    logic [SW-1:0] avg_target = '0;
    logic init, wen, ready, busy;
    logic [AW-1:0] address;
    logic [SW-1:0] n_avg;
    int checks = 0;
    int failures = 0;
    int ready_count = 0;
    logic [SW-1:0] last_navg = '0;
    always #5 clk = ~clk;
    averager_sequencer #(
        .FAST_COUNT_WIDTH(FW),
        .SLOW_COUNT_WIDTH(SW),
        .CH_LOG2(CL),
        .OUT_LATENCY(L)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .clken(clken),
        .restart(restart),
        .count_max(count_max),
        .avg_target(avg_target),
        .init(init),
        .wen(wen),
        .address(address),
        .ready(ready),
        .busy(busy),
        .n_avg(n_avg)
    );
    typedef struct packed {
        logic          ready;
        logic          init;
        logic          wen;
        logic [AW-1:0] addr;
        logic [SW-1:0] cnt;
    } tup_t;
    typedef struct {
        logic          clken;
        logic          restart;
        logic          wen;
        logic          init;
        logic [AW-1:0] addr;
        logic          ready;
        logic          busy;
        logic [SW-1:0] navg;
    } vec_t;
    // reference model: sample position within a frame and frames completed
    tup_t q[$];
    bit m_run, m_first, m_pend;
    int m_pos, m_k, m_cm;
    logic [SW-1:0] m_navg;
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        q.delete();
        for (int i = 0; i < L - 1; i++) q.push_back('0);
        m_run = 0;
        m_first = 0;
        m_pend = 0;
        m_pos = 0;
        m_k = 0;
        m_cm = 0;
        m_navg = '0;
    endtask
    task automatic model_step(input logic c, input logic r, output tup_t o);
        tup_t t;
        int per, k1;
        bit last, fin;
        per = m_cm + 1;
        k1 = (m_k + 1 > SMAX) ? SMAX : m_k + 1;
        last = m_run && c && (m_pos == per * NCH - 1);
        fin = last && (m_pend || r || (avg_target != 0 && k1 == int'(avg_target)));
        t.wen = m_run && c;
        t.init = t.wen && m_first;
        t.addr = AW'((m_pos / per) * 32 + m_pos % per);
        t.ready = fin;
        t.cnt = SW'(k1);
        if (!m_run) begin
            if (r) begin
                m_run = 1;
                m_first = 1;
                m_cm = int'(count_max);
                m_pos = 0;
                m_k = 0;
                m_pend = 0;
            end
        end else begin
            m_pend = m_pend || r;
            if (c) begin
                if (last) begin
                    m_pos = 0;
                    m_cm = int'(count_max);
                    if (fin) begin
                        m_k = 0;
                        m_first = 1;
                        if (!m_pend) m_run = 0;
                        m_pend = 0;
                    end else begin
                        m_k = k1;
                        m_first = 0;
                    end
                end else m_pos++;
            end
        end
        q.push_back(t);
        o = q.pop_front();
        if (o.ready) m_navg = o.cnt;
    endtask
    task automatic step(input logic c, input logic r);
        tup_t e;
        clken = c;
        restart = r;
        model_step(c, r, e);
        @(posedge clk);
        #1;
        check("outputs{rdy,init,wen,addr,busy,navg}", {ready, init, wen, address, busy, n_avg},
              {e.ready, e.init, e.wen, e.addr, m_run, m_navg});
        if (ready) begin
            ready_count++;
            last_navg = n_avg;
        end
        restart = 1'b0;
    endtask
    task automatic do_reset();
        #3 resetn = 1'b0;
        #1 check("async_reset_outputs", {ready, init, wen, address, busy, n_avg}, '0);
        model_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask
    initial begin
        vec_t vt[20];
        int s;
        for (int j = 0; j < 20; j++) begin
            s = j - 2;
            vt[j].clken = 1'b1;
            vt[j].restart = (j == 0);
            vt[j].wen = (s >= 0 && s < 16);
            vt[j].init = (s >= 0 && s < 8);
            vt[j].addr = (s >= 0 && s < 16) ? AW'(((s % 8) / 4) * 32 + s % 4) : '0;
            vt[j].ready = (s == 15);
            vt[j].busy = (j < 16);
            vt[j].navg = (j >= 17) ? SW'(2) : '0;
        end
        #2 resetn = 1'b0;
        model_reset();
        #1 check("reset_outputs", {ready, init, wen, address, busy, n_avg}, '0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        check("idle_outputs", {ready, init, wen, address, busy}, '0);
        count_max = 5'd3;
        avg_target = 10'd2;
        for (int j = 0; j < 20; j++) begin
            step(vt[j].clken, vt[j].restart);
            check("single_shot_table", {wen, init, address, ready, busy, n_avg},
                  {vt[j].wen, vt[j].init, vt[j].addr, vt[j].ready, vt[j].busy, vt[j].navg});
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("done_idle_busy_navg", {busy, wen, n_avg}, {1'b0, 1'b0, SW'(2)});
        avg_target = '0;
        count_max = 5'd15;
        ready_count = 0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 80; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        check("continuous_restart_ready_count", ready_count, 1);
        check("continuous_restart_navg", last_navg, 3);
        for (int i = 0; i < 40; i++) step(i[0], 1'b0);
        do_reset();
        step(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        count_max = '0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        count_max = 5'd5;
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        count_max = 5'd2;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
        do_reset();
        count_max = '0;
        ready_count = 0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 2060; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        check("saturation_ready_count", ready_count, 1);
        check("saturation_navg", last_navg, SMAX);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) count_max = FW'($urandom_range(7));
            if ($urandom_range(29) == 0) avg_target = SW'($urandom_range(4));
            step($urandom_range(3) != 0, $urandom_range(63) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
